uart_rx: RTL and testbench

//   Asynchronous serial receiver; the receive-side counterpart of the uart transmitter.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Asynchronous 8N1-style serial receiver: 2-FF input synchronizer, mid-bit sampling FSM,
// one-cycle data_valid / frame_error pulses and a BREAK state that rides out held-low lines.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int BAUD      = 9600,
   parameter int SYS_CLK   = 12000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 rx_wire,
   output logic [DATA_BITS-1:0] rx_output,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   // rx_wire is asynchronous; only sync_q[1] may feed decisions.
   logic [1:0] sync_q;
   logic       rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_wire};
      end
   end

   assign rx_sync = sync_q[1];

   state_t               state, state_next;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic [DATA_BITS-1:0] shreg, shreg_next;
   logic [DATA_BITS-1:0] rx_output_next;
   logic                 data_valid_next;
   logic                 frame_error_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         idx         <= '0;
         shreg       <= '0;
         rx_output   <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         idx         <= idx_next;
         shreg       <= shreg_next;
         rx_output   <= rx_output_next;
         data_valid  <= data_valid_next;
         frame_error <= frame_error_next;
      end
   end

   always_comb begin
      state_next       = state;
      bit_cnt_next     = bit_cnt;
      idx_next         = idx;
      shreg_next       = shreg;
      rx_output_next   = rx_output;
      data_valid_next  = 1'b0;
      frame_error_next = 1'b0;

      if (!enable) begin
         // Disabling abandons any frame in flight but keeps the last good word.
         state_next   = IDLE;
         bit_cnt_next = '0;
         idx_next     = '0;
         shreg_next   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state_next   = START;
                  bit_cnt_next = '0;
               end
            end

            START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt_next = '0;
                  if (!rx_sync) begin
                     state_next = DATA;
                     idx_next   = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_next = '0;
                  shreg_next   = {rx_sync, shreg[DATA_BITS-1:1]};
                  idx_next     = idx + 1'b1;
                  if (idx == IDX_LAST) begin
                     state_next = STOP;
                  end
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end

            STOP: begin
               // Leaving at mid-stop lets a start edge right after the stop bit be caught.
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_next = '0;
                  if (rx_sync) begin
                     rx_output_next  = shreg;
                     data_valid_next = 1'b1;
                     state_next      = IDLE;
                  end else begin
                     frame_error_next = 1'b1;
                     state_next       = BREAK;
                  end
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end

            BREAK: begin
               if (rx_sync) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next   = IDLE;
               bit_cnt_next = '0;
               idx_next     = '0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, expected bytes queued at frame start
// and popped by a monitor on every data_valid pulse.
module tb_uart_rx;

   localparam int DB      = 8;
   localparam int BAUD    = 9600;
   localparam int SYS_CLK = 153600;
   localparam int CPB     = SYS_CLK / BAUD;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          rx_wire;
   logic [DB-1:0] rx_output;
   logic          data_valid;
   logic          frame_error;
   logic          busy;

   uart_rx #(.DATA_BITS(DB), .BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .rx_wire     (rx_wire),
      .rx_output   (rx_output),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   int busy_cnt = 0;
   int both_cnt = 0;
   int dv_cyc = 0;

   logic [DB-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (data_valid && frame_error) both_cnt++;
      if (frame_error) fe_cnt++;
      if (data_valid) begin
         dv_cnt++;
         dv_cyc = cyc;
         if (exp_q.size() == 0) check("unexpected_data_valid", 32'd1, 32'd0);
         else check("rx_output_scoreboard", 32'(rx_output), 32'(exp_q.pop_front()));
      end
   end

   // driver tasks
   task automatic drive_bit(input logic v);
      rx_wire = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DB-1:0] data, input logic stop);
      if (stop) exp_q.push_back(data);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(data[i]);
      drive_bit(stop);
   endtask

   task automatic idle_clks(input int n);
      rx_wire = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_not_busy(input string tag, input int max_clks);
      int k;
      k = 0;
      while (busy && k < max_clks) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int t0, dv0, fe0, b0;

      rst_n = 1'b0;
      enable = 1'b0;
      rx_wire = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_rx_output", 32'(rx_output), 32'd0);
      check("reset_data_valid", 32'(data_valid), 32'd0);
      check("reset_frame_error", 32'(frame_error), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      enable = 1'b1;

      // idle line
      b0 = busy_cnt;
      idle_clks(10 * CPB);
      check("idle_busy_cycles", 32'(busy_cnt - b0), 32'd0);
      check("idle_dv", 32'(dv_cnt), 32'd0);
      check("idle_fe", 32'(fe_cnt), 32'd0);

      // single frame 0xA5 with latency measurement
      t0 = cyc;
      send_frame(8'hA5, 1'b1);
      idle_clks(CPB);
      check("a5_dv_count", 32'(dv_cnt), 32'd1);
      check("a5_rx_output", 32'(rx_output), 32'hA5);
      check("a5_fe", 32'(fe_cnt), 32'd0);
      check("a5_latency", 32'(dv_cyc - t0), 32'(DB * CPB + CPB + CPB / 2 + 3));

      // back-to-back frames, no idle gap
      dv0 = dv_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle_clks(CPB);
      check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
      check("b2b_rx_output", 32'(rx_output), 32'hFF);

      // short low glitch shorter than half a bit
      dv0 = dv_cnt;
      b0 = busy_cnt;
      rx_wire = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      idle_clks(2 * CPB);
      check("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
      check("glitch_rx_output", 32'(rx_output), 32'hFF);

      // bad stop bit, line held low, then a good frame
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h81, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      check("break_busy", 32'(busy), 32'd1);
      drive_bit(1'b0);
      idle_clks(4);
      wait_not_busy("break_release", 4 * CPB);
      check("ferr_count", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_no_dv", 32'(dv_cnt - dv0), 32'd0);
      check("ferr_rx_output", 32'(rx_output), 32'hFF);
      idle_clks(CPB);
      send_frame(8'h3C, 1'b1);
      idle_clks(CPB);
      check("after_ferr_rx_output", 32'(rx_output), 32'h3C);

      // transmitter-style frame 0x81
      send_frame(8'h81, 1'b1);
      idle_clks(CPB);
      check("tx81_rx_output", 32'(rx_output), 32'h81);

      // reset mid-frame
      dv0 = dv_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst_n = 1'b0;
      rx_wire = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_rx_output", 32'(rx_output), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_dv", 32'(data_valid), 32'd0);
      check("midrst_fe", 32'(frame_error), 32'd0);
      rst_n = 1'b1;
      idle_clks(2 * CPB);
      check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
      send_frame(8'h5A, 1'b1);
      idle_clks(CPB);
      check("midrst_next_rx_output", 32'(rx_output), 32'h5A);

      // enable dropped mid-frame
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      enable = 1'b0;
      rx_wire = 1'b1;
      repeat (2) @(negedge clk);
      check("dis_busy", 32'(busy), 32'd0);
      check("dis_rx_output", 32'(rx_output), 32'h5A);
      idle_clks(2 * CPB);
      enable = 1'b1;
      idle_clks(CPB);
      check("dis_no_dv", 32'(dv_cnt - dv0), 32'd0);
      check("dis_no_fe", 32'(fe_cnt - fe0), 32'd0);
      send_frame(8'h5A, 1'b1);
      idle_clks(CPB);
      check("dis_next_dv_count", 32'(dv_cnt - dv0), 32'd1);
      check("dis_next_rx_output", 32'(rx_output), 32'h5A);

      // final report
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("dv_fe_overlap", 32'(both_cnt), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
